ex_stage: RTL
=============

# ex_stage

Execute stage of the 5-stage pipelined CPU, between ID and MEM. Holds the ID/EX pipeline register, evaluates the ALU operation, computes the branch target, and presents the EX-side signals the MEM stage latches into its EX/MEM register. Also contains an iterative 32-cycle multiply/divide unit with HI/LO registers; while it runs, the block stalls the upstream stages and issues bubbles downstream.

## Interface
Parameters:
- `MULDIV_CYCLES`, default 32: iterations per multiply/divide; fixed at 32 for 32-bit operands.

Ports:
- `CLK`  in  1  pipeline clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `RegWriteD`, `MemtoRegD`, `MemWriteD`, `BranchD`, `JumpD`, `ALUSrcD`  in  1 each  ID control signals.
- `ALUopD`  in  6  operation code; encoding under Operation.
- `RD1_in`, `RD2_in`  in  32  register operands, already forwarded.
- `SignImm_in`  in  32  sign-extended immediate.
- `shamt_in`  in  5  shift amount.
- `instr_index_in`  in  26  J/JAL target field.
- `PCPlus4_in`  in  32  PC+4 of the instruction.
- `wb_addr_in`  in  5  destination register.
- `FlushE`  in  1  hazard-unit flush (taken branch/jump in MEM).
- `RegWriteE`, `MemtoRegE`, `MemWriteE`, `BranchE`, `JumpE`  out  1 each  to MEM.
- `ALUopE`  out  6  to MEM.
- `WriteData_out`  out  32  `RD2` of the latched instruction.
- `PCPlus4_out`  out  32;  `PCBranch_out`  out  32;  `wb_addr_out`  out  5;  `ALUOut_out`  out  32.
- `StallE`  out  1  high: IF/ID must hold; ID/EX does not load.

## Operation
- ID/EX register: on posedge CLK: if `RESET`, clear all fields; else if `FlushE`, load a bubble (all control bits 0, `ALUopD`=0); else if `!StallE`, load the D inputs; else hold.
- Operand B is `SignImm` when `ALUSrc`=1, otherwise `RD2`. `PCBranch_out = PCPlus4 + (SignImm << 2)`, mod 2^32.
- `ALUop` encoding and `ALUOut` result: 0 ADD; 1 SUB (both wrap mod 2^32, no overflow trap); 2 AND; 3 OR; 4 XOR; 5 NOR; 6 SLT (signed, result 0/1); 7 SLTU; 8 SLL by shamt; 9 SRL; 10 SRA; 11 LUI (`B<<16`); 12 BEQ (1 if A==B); 13 BNE (1 if A!=B); 14 J and 16 JAL (`{PCPlus4[31:28], instr_index, 2'b00}`); 15 JR (A); 17 MULT; 18 MULTU; 19 DIV; 20 DIVU; 21 MFHI; 22 MFLO. Any other code gives 0.
- Mul/div FSM states:
  - IDLE: when a mul/div op is latched, raise `StallE` and go to BUSY with `count`=0.
  - BUSY: raise `StallE` and run one shift-add or restoring-subtract step per cycle. When `count`=31, write HI/LO and go to DONE; otherwise increment `count`.
  - DONE: `StallE`=0 so the ID/EX register advances; return to IDLE.
- Signed ops work on magnitudes and fix the sign at the end. Division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: LO=32'hFFFFFFFF, HI=dividend.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MULT/DIV ops never write a GPR (`RegWriteD`=0 from ID).
- While `StallE`=1, outputs `RegWriteE`, `MemWriteE`, `BranchE` and `JumpE` are 0 (bubble to MEM). In DONE, the mul/div op itself leaves as a NOP.

## Timing
- Reset: every output is 0; FSM in IDLE; `count`=0; HI=LO=0. Reset during BUSY aborts the operation and leaves HI/LO at 0.
- Non-mul/div ops: outputs are combinational from the ID/EX register, valid the same cycle the instruction is latched. Latency is 1 cycle.
- Mul/div: `StallE` is high for 33 consecutive cycles (IDLE entry plus 32 BUSY) and low in DONE. HI/LO are visible from the DONE cycle, so an MFHI/MFLO immediately after reads the new value.
- `FlushE` has priority over `StallE` and FSM progress: it aborts to IDLE, leaves HI/LO unchanged and loads a bubble.
- `RESET` has priority over `FlushE`.

## Configuration
- `EX_MULDIV_EN` defined: the FSM and HI/LO are built, with behaviour as above.
- `EX_MULDIV_EN` undefined: no FSM or HI/LO. Codes 17–22 give `ALUOut`=0 and act as NOPs; `StallE` is tied to 0.

## Test plan
- ADD: `RD1`=0xFFFFFFFF, `RD2`=2, `ALUSrc`=0 -> `ALUOut_out`=1 in the same cycle, `RegWriteE`=1.
- BEQ: `RD1`=`RD2`=5, `PCPlus4`=0x100, `SignImm`=-4 -> `ALUOut_out`=1, `PCBranch_out`=0xF0, `BranchE`=1.
- JAL: `PCPlus4`=0x40000004, `instr_index`=0x000010 -> `ALUOut_out`=0x40000040, `JumpE`=1.
- MULT -5 × 7, then MFLO, then MFHI -> `StallE` high for exactly 33 cycles; MFLO gives 0xFFFFFFDD; MFHI gives 0xFFFFFFFF.
- DIVU 9/0, then MFLO/MFHI -> 0xFFFFFFFF / 9. DIV 0x80000000 / 0xFFFFFFFF -> LO 0x80000000, HI 0.
- `FlushE` at BUSY `count`=10 -> `StallE`=0 the next cycle, HI/LO unchanged, bubble outputs. `RESET` at BUSY `count`=20 -> all outputs 0 the next cycle, HI=LO=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, ALU, branch target, optional iterative mul/div.
// Define EX_MULDIV_EN to build the mul/div FSM and the HI/LO registers.
module ex_stage #(
   parameter int unsigned MULDIV_CYCLES = 32
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        RegWriteD,
   input  logic        MemtoRegD,
   input  logic        MemWriteD,
   input  logic        BranchD,
   input  logic        JumpD,
   input  logic        ALUSrcD,
   input  logic [5:0]  ALUopD,
   input  logic [31:0] RD1_in,
   input  logic [31:0] RD2_in,
   input  logic [31:0] SignImm_in,
   input  logic [4:0]  shamt_in,
   input  logic [25:0] instr_index_in,
   input  logic [31:0] PCPlus4_in,
   input  logic [4:0]  wb_addr_in,
   input  logic        FlushE,
   output logic        RegWriteE,
   output logic        MemtoRegE,
   output logic        MemWriteE,
   output logic        BranchE,
   output logic        JumpE,
   output logic [5:0]  ALUopE,
   output logic [31:0] WriteData_out,
   output logic [31:0] PCPlus4_out,
   output logic [31:0] PCBranch_out,
   output logic [4:0]  wb_addr_out,
   output logic [31:0] ALUOut_out,
   output logic        StallE
);
   localparam int unsigned CNT_W = $clog2(MULDIV_CYCLES);

   localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB  = 6'd1,  OP_AND  = 6'd2,  OP_OR   = 6'd3;
   localparam logic [5:0] OP_XOR  = 6'd4,  OP_NOR  = 6'd5,  OP_SLT  = 6'd6,  OP_SLTU = 6'd7;
   localparam logic [5:0] OP_SLL  = 6'd8,  OP_SRL  = 6'd9,  OP_SRA  = 6'd10, OP_LUI  = 6'd11;
   localparam logic [5:0] OP_BEQ  = 6'd12, OP_BNE  = 6'd13, OP_J    = 6'd14, OP_JR   = 6'd15;
   localparam logic [5:0] OP_JAL  = 6'd16, OP_MULT = 6'd17, OP_MULTU= 6'd18, OP_DIV  = 6'd19;
   localparam logic [5:0] OP_DIVU = 6'd20, OP_MFHI = 6'd21, OP_MFLO = 6'd22;

   logic        r_regwrite, r_memtoreg, r_memwrite, r_branch, r_jump, r_alusrc;
   logic [5:0]  r_aluop;
   logic [31:0] r_rd1, r_rd2, r_imm, r_pc4;
   logic [4:0]  r_shamt, r_wb;
   logic [25:0] r_idx;

   logic        w_stall, w_done, w_bubble;
   logic [31:0] w_b, w_alu;

   // ID/EX register; a flush bubble clears every field
   always_ff @(posedge CLK) begin
      if (RESET || FlushE) begin
         r_regwrite <= 1'b0; r_memtoreg <= 1'b0; r_memwrite <= 1'b0;
         r_branch   <= 1'b0; r_jump     <= 1'b0; r_alusrc   <= 1'b0;
         r_aluop    <= '0;   r_rd1      <= '0;   r_rd2      <= '0;
         r_imm      <= '0;   r_pc4      <= '0;   r_shamt    <= '0;
         r_wb       <= '0;   r_idx      <= '0;
      end else if (!w_stall) begin
         r_regwrite <= RegWriteD; r_memtoreg <= MemtoRegD; r_memwrite <= MemWriteD;
         r_branch   <= BranchD;   r_jump     <= JumpD;     r_alusrc   <= ALUSrcD;
         r_aluop    <= ALUopD;    r_rd1      <= RD1_in;    r_rd2      <= RD2_in;
         r_imm      <= SignImm_in; r_pc4     <= PCPlus4_in; r_shamt   <= shamt_in;
         r_wb       <= wb_addr_in; r_idx     <= instr_index_in;
      end
   end

`ifdef EX_MULDIV_EN
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_acc, r_mq, r_mcand, r_hi, r_lo;

   logic        w_is_md, w_is_div, w_signed, w_a_neg, w_b_neg;
   logic [31:0] w_a_mag, w_b_mag, w_acc_n, w_mq_n, w_shl, w_hi_n, w_lo_n;
   logic [32:0] w_sum;
   logic [63:0] w_prod;
   logic        w_ge;

   assign w_is_md  = (r_aluop == OP_MULT) || (r_aluop == OP_MULTU) ||
                     (r_aluop == OP_DIV)  || (r_aluop == OP_DIVU);
   assign w_is_div = (r_aluop == OP_DIV)  || (r_aluop == OP_DIVU);
   assign w_signed = (r_aluop == OP_MULT) || (r_aluop == OP_DIV);
   assign w_a_neg  = w_signed & r_rd1[31];
   assign w_b_neg  = w_signed & r_rd2[31];
   assign w_a_mag  = w_a_neg ? -r_rd1 : r_rd1;
   assign w_b_mag  = w_b_neg ? -r_rd2 : r_rd2;
   assign w_stall  = ((r_state == S_IDLE) && w_is_md) || (r_state == S_BUSY);
   assign w_done   = (r_state == S_DONE);

   // One shift-add (mul) or restoring-subtract (div) step; acc:mq is the working pair
   always_comb begin
      w_sum   = {1'b0, r_acc} + {1'b0, (r_mq[0] ? r_mcand : 32'd0)};
      w_shl   = {r_acc[30:0], r_mq[31]};
      w_ge    = r_acc[31] | (w_shl >= r_mcand);
      w_acc_n = w_sum[32:1];
      w_mq_n  = {w_sum[0], r_mq[31:1]};
      if (w_is_div) begin
         w_acc_n = w_ge ? (w_shl - r_mcand) : w_shl;
         w_mq_n  = {r_mq[30:0], w_ge};
      end
      w_prod = {w_acc_n, w_mq_n};
      if (w_a_neg ^ w_b_neg) w_prod = -w_prod;
      w_hi_n = w_prod[63:32];
      w_lo_n = w_prod[31:0];
      if (w_is_div) begin
         w_lo_n = (w_a_neg ^ w_b_neg) ? -w_mq_n : w_mq_n;
         w_hi_n = w_a_neg ? -w_acc_n : w_acc_n;
         if (r_rd2 == 32'd0) begin
            w_lo_n = 32'hFFFF_FFFF;
            w_hi_n = r_rd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE; r_count <= '0; r_acc <= '0; r_mq <= '0;
         r_mcand <= '0;     r_hi    <= '0; r_lo  <= '0;
      end else if (FlushE) begin
         r_state <= S_IDLE; r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_is_md) begin
               r_state <= S_BUSY; r_count <= '0;
               r_acc   <= '0;     r_mq    <= w_a_mag; r_mcand <= w_b_mag;
            end
            S_BUSY: begin
               r_acc <= w_acc_n; r_mq <= w_mq_n;
               if (r_count == CNT_W'(MULDIV_CYCLES - 1)) begin
                  r_hi <= w_hi_n; r_lo <= w_lo_n; r_state <= S_DONE;
               end else begin
                  r_count <= r_count + CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE; r_count <= '0;
            end
         endcase
      end
   end
`else
   logic [CNT_W-1:0] w_unused_cycles;
   assign w_unused_cycles = CNT_W'(MULDIV_CYCLES);
   assign w_stall = 1'b0;
   assign w_done  = 1'b0;
`endif

   assign w_b = r_alusrc ? r_imm : r_rd2;

   // ALU result; unlisted codes (and mul/div issue codes) give 0
   always_comb begin
      w_alu = 32'd0;
      case (r_aluop)
         OP_ADD:  w_alu = r_rd1 + w_b;
         OP_SUB:  w_alu = r_rd1 - w_b;
         OP_AND:  w_alu = r_rd1 & w_b;
         OP_OR:   w_alu = r_rd1 | w_b;
         OP_XOR:  w_alu = r_rd1 ^ w_b;
         OP_NOR:  w_alu = ~(r_rd1 | w_b);
         OP_SLT:  w_alu = 32'($signed(r_rd1) < $signed(w_b));
         OP_SLTU: w_alu = 32'(r_rd1 < w_b);
         OP_SLL:  w_alu = w_b << r_shamt;
         OP_SRL:  w_alu = w_b >> r_shamt;
         OP_SRA:  w_alu = $unsigned($signed(w_b) >>> r_shamt);
         OP_LUI:  w_alu = w_b << 16;
         OP_BEQ:  w_alu = 32'(r_rd1 == w_b);
         OP_BNE:  w_alu = 32'(r_rd1 != w_b);
         OP_J, OP_JAL: w_alu = {r_pc4[31:28], r_idx, 2'b00};
         OP_JR:   w_alu = r_rd1;
`ifdef EX_MULDIV_EN
         OP_MFHI: w_alu = r_hi;
         OP_MFLO: w_alu = r_lo;
`endif
         default: w_alu = 32'd0;
      endcase
   end

   assign w_bubble      = w_stall | w_done;
   assign RegWriteE     = r_regwrite & ~w_bubble;
   assign MemtoRegE     = r_memtoreg;
   assign MemWriteE     = r_memwrite & ~w_bubble;
   assign BranchE       = r_branch & ~w_bubble;
   assign JumpE         = r_jump & ~w_bubble;
   assign ALUopE        = r_aluop;
   assign WriteData_out = r_rd2;
   assign PCPlus4_out   = r_pc4;
   assign PCBranch_out  = r_pc4 + (r_imm << 2);
   assign wb_addr_out   = r_wb;
   assign ALUOut_out    = w_alu;
   assign StallE        = w_stall;
endmodule
